// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART coprocessor command protocol.
package uart_cmd_pkg;

  localparam int unsigned FRAME_BYTES  = 18;
  localparam int unsigned PAYLOAD_BITS = 128;
  localparam int unsigned BYTE_W       = $clog2(FRAME_BYTES);

  localparam logic [7:0] CMD_TEST    = 8'h41; // "A"
  localparam logic [7:0] CMD_KEY     = 8'h43; // "C"
  localparam logic [7:0] CMD_TEXT    = 8'h44; // "D"
  localparam logic [7:0] CMD_ENC     = 8'h45; // "E"
  localparam logic [7:0] CMD_RD_RES  = 8'h40; // "@"
  localparam logic [7:0] CMD_RD_KEY  = 8'h61; // "a"
  localparam logic [7:0] CMD_RD_TEXT = 8'h62; // "b"

  // Byte serialiser states
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Frame-level states
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_DONE
  } frame_state_e;

  // Byte k of the frame {cmd, payload, cmd}: cmd at both ends, payload LSB byte first.
  function automatic logic [7:0] frame_byte(
    input logic [7:0]              cmd,
    input logic [PAYLOAD_BITS-1:0] payload,
    input logic [BYTE_W-1:0]       idx
  );
    logic [PAYLOAD_BITS-1:0] shifted;
    shifted = payload >> {idx - BYTE_W'(1), 3'b000};
    if (idx == '0 || idx == BYTE_W'(FRAME_BYTES - 1)) begin
      return cmd;
    end
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/uart_cmd_frame_tx_byte.sv
// 8N1 byte serialiser with a valid/ready handshake and an end-of-byte strobe.
module uart_tx_byte
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 897
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_e        state;
  tx_state_e        state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             baud_last;
  logic             load;

  assign baud_last  = (baud_cnt == CNT_LAST);
  // A new byte is taken in the last cycle of the stop bit so the next start
  // bit follows without any idle time on the line.
  assign byte_done  = (state == TX_STOP) && baud_last;
  assign byte_ready = (state == TX_IDLE) || byte_done;
  assign load       = byte_valid && byte_ready;

  // Next-state decode for the bit sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (byte_valid) state_nxt = TX_START;
      TX_START: if (baud_last) state_nxt = TX_DATA;
      TX_DATA:  if (baud_last && bit_cnt == 3'd7) state_nxt = TX_STOP;
      TX_STOP:  if (baud_last) state_nxt = byte_valid ? TX_START : TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // State register, baud/bit counters, shift register and registered line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg    <= byte_data;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        tx       <= 1'b0;
      end else if (state != TX_IDLE) begin
        if (baud_last) begin
          baud_cnt <= '0;
          case (state)
            TX_START: tx <= shreg[0];
            TX_DATA: begin
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                tx      <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {1'b0, shreg[7:1]};
                tx      <= shreg[1];
              end
            end
            TX_STOP: tx <= 1'b1;
            default: tx <= 1'b1;
          endcase
        end else begin
          baud_cnt <= baud_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Builds the 18-byte {cmd, payload, cmd} frame and feeds it to the byte serialiser.
module uart_cmd_frame_tx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 103_340_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd,
  input  logic [PAYLOAD_BITS-1:0] payload,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);

  frame_state_e            state;
  frame_state_e            state_nxt;
  logic [7:0]              cmd_q;
  logic [PAYLOAD_BITS-1:0] payload_q;
  logic [BYTE_W-1:0]       byte_idx;
  logic                    accept;
  logic                    last_byte;
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready;
  logic                    byte_done;

  assign accept    = cmd_valid && cmd_ready;
  assign last_byte = (byte_idx == BYTE_W'(FRAME_BYTES - 1));

  // Frame sequencing and byte hand-off to the serialiser.
  // Byte 0 comes straight from the cmd input so its start bit lands on the
  // cycle right after the handshake; later bytes come from the latch.
  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    byte_data  = '0;
    case (state)
      FR_IDLE, FR_DONE: begin
        if (accept) begin
          state_nxt  = FR_SEND;
          byte_valid = 1'b1;
          byte_data  = cmd;
        end else begin
          state_nxt = FR_IDLE;
        end
      end
      FR_SEND: begin
        if (byte_done) begin
          if (last_byte) begin
            state_nxt = FR_DONE;
          end else begin
            byte_valid = byte_ready;
            byte_data  = frame_byte(cmd_q, payload_q, byte_idx + BYTE_W'(1));
          end
        end
      end
      default: state_nxt = FR_IDLE;
    endcase
  end

  // State, frame latch, byte counter and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FR_IDLE;
      cmd_q      <= '0;
      payload_q  <= '0;
      byte_idx   <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q     <= cmd;
        payload_q <= payload;
        byte_idx  <= '0;
      end else if (state == FR_SEND && byte_done) begin
        byte_idx <= last_byte ? '0 : byte_idx + BYTE_W'(1);
      end
      cmd_ready  <= (state_nxt != FR_SEND);
      busy       <= (state_nxt == FR_SEND);
      frame_done <= (state_nxt == FR_DONE);
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .tx        (tx)
  );

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Self-checking bench for uart_cmd_frame_tx with a mid-bit UART monitor and byte scoreboard.
module tb_uart_cmd_frame_tx;

  localparam int unsigned BD        = 4;
  localparam int unsigned FRAME_CYC = 18 * 10 * BD;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [7:0]   cmd = '0;
  logic [127:0] payload = '0;
  logic         cmd_ready;
  logic         tx;
  logic         busy;
  logic         frame_done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  uart_cmd_frame_tx #(
    .BAUD_DIV(BD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .payload   (payload),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Expected byte order: cmd, payload LSB byte first, cmd trailer; n limits the count.
  task automatic push_frame(input logic [7:0] c, input logic [127:0] p, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      logic [7:0] b;
      if (k == 0 || k == 17) b = c;
      else b = p[8*(k-1) +: 8];
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(FRAME_CYC) * 2; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // UART monitor: samples each bit in the middle of its BD-cycle window
  initial begin : uart_monitor
    logic [9:0] bits;
    logic [7:0] exp;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        repeat (BD / 2 - 1) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) repeat (BD) @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bits[i] = tx;
        end
        if (!aborted) begin
          total++;
          if (bits[0] !== 1'b0) begin
            bad++;
            $display("FAIL start_bit: got %b want 0", bits[0]);
          end
          total++;
          if (bits[9] !== 1'b1) begin
            bad++;
            $display("FAIL stop_bit: got %b want 1", bits[9]);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_byte: got %02h want none", bits[8:1]);
          end else begin
            exp = exp_q.pop_front();
            if (bits[8:1] !== exp) begin
              bad++;
              $display("FAIL frame_byte: got %02h want %02h", bits[8:1], exp);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({tx, cmd_ready, busy, frame_done} !== 4'b1100) begin
        bad++;
        $display("FAIL reset_idle: tx/ready/busy/done=%b want 1100 cycle %0d",
                 {tx, cmd_ready, busy, frame_done}, i);
      end
    end
  endtask

  task automatic test_single_frame();
    int unsigned cnt;
    @(negedge clk);
    cmd = 8'h43;
    payload = 128'h000102030405060708090a0b0c0d0e0f;
    cmd_valid = 1'b1;
    push_frame(cmd, payload, 18);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({cmd_ready, busy, tx} !== 3'b010) begin
      bad++;
      $display("FAIL accept_next: ready/busy/tx=%b want 010", {cmd_ready, busy, tx});
    end
    cnt = 1;
    for (int i = 0; i < int'(FRAME_CYC) + 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
    end
    total++;
    if (cnt != FRAME_CYC) begin
      bad++;
      $display("FAIL busy_len: got %0d want %0d", cnt, FRAME_CYC);
    end
    total++;
    if ({frame_done, tx, cmd_ready} !== 3'b111) begin
      bad++;
      $display("FAIL done_cycle: done/tx/ready=%b want 111", {frame_done, tx, cmd_ready});
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got %b want 0", frame_done);
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_bytes_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge clk);
    cmd = 8'h44;
    payload = '0;
    cmd_valid = 1'b1;
    push_frame(cmd, payload, 18);
    @(negedge clk);
    cmd = 8'h45;
    push_frame(cmd, payload, 18);
    wait_done(ok);
    total++;
    if (!ok || cmd_ready !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done: ok=%0d ready=%b tx=%b want 1 1 1", ok, cmd_ready, tx);
    end
    @(negedge clk);
    total++;
    if ({tx, busy, frame_done, cmd_ready} !== 4'b0100) begin
      bad++;
      $display("FAIL b2b_restart: tx/busy/done/ready=%b want 0100",
               {tx, busy, frame_done, cmd_ready});
    end
    cmd_valid = 1'b0;
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_second_done: got 0 want 1");
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_bytes_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_ignore_busy();
    bit ok;
    bit ready_seen;
    bit line_active;
    ready_seen  = 1'b0;
    line_active = 1'b0;
    @(negedge clk);
    cmd = 8'h43;
    payload = {$urandom, $urandom, $urandom, $urandom};
    cmd_valid = 1'b1;
    push_frame(cmd, payload, 18);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    cmd = 8'h41;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < int'(FRAME_CYC) * 2; i++) begin
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (cmd_ready !== 1'b0) ready_seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (!ok || ready_seen) begin
      bad++;
      $display("FAIL busy_ready: done=%0d ready_seen=%0d want 1 0", ok, ready_seen);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) line_active = 1'b1;
    end
    total++;
    if (line_active) begin
      bad++;
      $display("FAIL ignored_cmd: line_active=1 want 0");
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ignore_bytes_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit status_bad;
    status_bad = 1'b0;
    @(negedge clk);
    cmd = 8'h45;
    payload = {$urandom, $urandom, $urandom, $urandom};
    payload[39:32] = 8'h00;
    cmd_valid = 1'b1;
    push_frame(cmd, payload, 5);
    @(negedge clk);
    cmd_valid = 1'b0;
    // first start-bit cycle is 1; byte 5 bit 3 spans cycles 217..220
    repeat (217) @(negedge clk);
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_bit: tx=%b busy=%b want 0 1", tx, busy);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({tx, busy, cmd_ready, frame_done} !== 4'b1010) begin
      bad++;
      $display("FAIL async_reset: tx/busy/ready/done=%b want 1010",
               {tx, busy, cmd_ready, frame_done});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || cmd_ready !== 1'b1 || tx !== 1'b1) status_bad = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) status_bad = 1'b1;
    end
    total++;
    if (status_bad) begin
      bad++;
      $display("FAIL reset_hold: status_bad=1 want 0");
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL aborted_bytes_left: got %0d want 0", exp_q.size());
    end
    cmd = 8'h40;
    payload = {$urandom, $urandom, $urandom, $urandom};
    cmd_valid = 1'b1;
    push_frame(cmd, payload, 18);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL post_reset_done: got 0 want 1");
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL post_reset_bytes_left: got %0d want 0", exp_q.size());
    end
  endtask

  initial begin : main
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
